// File: rtl/mips_dbg_pkg.sv
// Shared types and helpers for the MIPS debug run/dump sequencer.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_READ,
        ST_OUT,
        ST_DONE
    } dbg_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Bytes per dump word.
    function automatic int unsigned bytes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Width of a word index able to reach 'words' itself (never below 1 bit).
    function automatic int unsigned idx_w(input int unsigned words);
        return (clog2(words + 1) > 0) ? clog2(words + 1) : 1;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects byte reads, arriving one cycle after each issue, into a little-endian word.
module byte_word_assembler
    import mips_dbg_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_ready_c_o
);

    localparam int unsigned       BYTES     = bytes_of(DATA_W);
    localparam int unsigned       LANE_W    = (clog2(BYTES) > 0) ? clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    logic              cap_q;
    logic [LANE_W-1:0] lane_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // New byte enters at the top; after BYTES shifts the first byte sits in lane 0.
    generate
        if (BYTES > 1) begin : g_shift
            assign word_d = {byte_i, word_q[DATA_W-1:8]};
        end else begin : g_single
            assign word_d = byte_i;
        end
    endgenerate

    // Capture pipeline: valid trails the issue strobe by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q  <= 1'b0;
            lane_q <= '0;
            word_q <= '0;
        end else begin
            cap_q <= issue_i;
            if (cap_q) begin
                word_q <= word_d;
                lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
            end
        end
    end

    assign word_o         = word_q;
    assign word_ready_c_o = cap_q && (lane_q == LAST_LANE);

endmodule

// File: rtl/run_dump_ctrl.sv
// Run/dump sequencer: holds the core in reset, runs it, freezes it, then streams a memory window.
module run_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int unsigned RST_HOLD   = 1,
    parameter int unsigned RUN_CYCLES = 125,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         halt,
    output logic                         cpu_rst,
    output logic                         dm_sel,
    output logic [ADDR_W-1:0]            dm_addr,
    output logic                         dm_rd,
    input  logic [7:0]                   dm_byte,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [DATA_W-1:0]            dump_data,
    output logic [idx_w(DUMP_WORDS)-1:0] dump_idx,
    output logic [CNT_W-1:0]             cycles_run,
    output logic                         done
);

    localparam int unsigned       BYTES       = bytes_of(DATA_W);
    localparam int unsigned       IDX_W       = idx_w(DUMP_WORDS);
    localparam int unsigned       ISS_W       = (clog2(BYTES) > 0) ? clog2(BYTES) : 1;
    localparam logic [31:0]       HOLD_LAST   = 32'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
    localparam bit                RUN_LIMITED = (RUN_CYCLES != 0);
    localparam bit                HAS_WORDS   = (DUMP_WORDS != 0);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DUMP_WORDS - 1);
    localparam logic [ISS_W-1:0]  ISS_LAST    = ISS_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE   = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(BYTES);

    dbg_state_e        state_q;
    logic [31:0]       hold_q;
    logic [ISS_W-1:0]  iss_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic              cpu_rst_q;
    logic              dm_sel_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic              dm_rd_q;
    logic              dump_valid_q;
    logic [IDX_W-1:0]  dump_idx_q;
    logic [CNT_W-1:0]  cycles_run_q;
    logic              done_q;
    logic              run_end_c;
    logic              word_ready_c;
    logic [DATA_W-1:0] asm_word;

    // Halt and budget expiry in the same cycle collapse into one exit.
    assign run_end_c = halt || (RUN_LIMITED && (cycles_run_q == RUN_LAST));

    // Sequencer: every output is a register updated on the transition that changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            hold_q       <= '0;
            iss_q        <= '0;
            w_addr_q     <= ADDR_BASE;
            cpu_rst_q    <= 1'b1;
            dm_sel_q     <= 1'b0;
            dm_addr_q    <= '0;
            dm_rd_q      <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            cycles_run_q <= '0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (!(&cycles_run_q)) cycles_run_q <= cycles_run_q + CNT_W'(1);
                    if (run_end_c) begin
                        cpu_rst_q <= 1'b1;
                        dm_sel_q  <= 1'b1;
                        if (HAS_WORDS) begin
                            state_q   <= ST_READ;
                            dm_rd_q   <= 1'b1;
                            dm_addr_q <= w_addr_q;
                            iss_q     <= '0;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (dm_rd_q) begin
                        if (iss_q == ISS_LAST) begin
                            dm_rd_q <= 1'b0;
                        end else begin
                            iss_q     <= iss_q + ISS_W'(1);
                            dm_addr_q <= dm_addr_q + ADDR_W'(1);
                        end
                    end
                    if (word_ready_c) begin
                        state_q      <= ST_OUT;
                        dump_valid_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (dump_ready) begin
                        dump_valid_q <= 1'b0;
                        dump_idx_q   <= dump_idx_q + IDX_W'(1);
                        w_addr_q     <= w_addr_q + ADDR_STEP;
                        if (dump_idx_q == IDX_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_READ;
                            dm_rd_q   <= 1'b1;
                            dm_addr_q <= w_addr_q + ADDR_STEP;
                            iss_q     <= '0;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: state_q <= ST_HOLD;
            endcase
        end
    end

    // Byte lanes are filled from the read strobe delayed by one cycle.
    byte_word_assembler #(
        .DATA_W(DATA_W)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .issue_i       (dm_rd_q),
        .byte_i        (dm_byte),
        .word_o        (asm_word),
        .word_ready_c_o(word_ready_c)
    );

    assign cpu_rst    = cpu_rst_q;
    assign dm_sel     = dm_sel_q;
    assign dm_addr    = dm_addr_q;
    assign dm_rd      = dm_rd_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = asm_word;
    assign dump_idx   = dump_idx_q;
    assign cycles_run = cycles_run_q;
    assign done       = done_q;

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Bench for run_dump_ctrl: three configurations sharing one clock, each with its own memory.
module tb_run_dump_ctrl;

    localparam int A_BASE  = 12;
    localparam int A_WORDS = 3;

    logic clk;
    int   errors;
    int   checks;

    // DUT A: hold 3, budget 10, 16-byte memory, window wraps past the top
    logic        rst_a, halt_a, cpu_rst_a, dm_sel_a, dm_rd_a, dump_valid_a, dump_ready_a, done_a;
    logic [3:0]  dm_addr_a;
    logic [7:0]  dm_byte_a;
    logic [31:0] dump_data_a, cycles_run_a;
    logic [1:0]  dump_idx_a;
    logic [7:0]  mem_a [16];
    logic [3:0]  addr_log_a [$];

    // DUT B: hold 1, budget 125, ended by halt, two words from address 0
    logic        rst_b, halt_b, cpu_rst_b, dm_sel_b, dm_rd_b, dump_valid_b, dump_ready_b, done_b;
    logic [11:0] dm_addr_b;
    logic [7:0]  dm_byte_b;
    logic [31:0] dump_data_b, cycles_run_b;
    logic [1:0]  dump_idx_b;
    logic [7:0]  mem_b [4096];
    int          rd_cnt_b;

    // DUT C: no words to dump
    logic        rst_c, halt_c, cpu_rst_c, dm_sel_c, dm_rd_c, dump_valid_c, dump_ready_c, done_c;
    logic [11:0] dm_addr_c;
    logic [7:0]  dm_byte_c;
    logic [31:0] dump_data_c, cycles_run_c;
    logic [0:0]  dump_idx_c;
    int          rd_cnt_c;
    int          vld_cnt_c;

    run_dump_ctrl #(.RST_HOLD(3), .RUN_CYCLES(10), .ADDR_W(4), .DATA_W(32),
                    .DUMP_BASE(A_BASE), .DUMP_WORDS(A_WORDS), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst_a), .halt(halt_a), .cpu_rst(cpu_rst_a), .dm_sel(dm_sel_a),
        .dm_addr(dm_addr_a), .dm_rd(dm_rd_a), .dm_byte(dm_byte_a), .dump_valid(dump_valid_a),
        .dump_ready(dump_ready_a), .dump_data(dump_data_a), .dump_idx(dump_idx_a),
        .cycles_run(cycles_run_a), .done(done_a));

    run_dump_ctrl #(.RST_HOLD(1), .RUN_CYCLES(125), .ADDR_W(12), .DATA_W(32),
                    .DUMP_BASE(0), .DUMP_WORDS(2), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst_b), .halt(halt_b), .cpu_rst(cpu_rst_b), .dm_sel(dm_sel_b),
        .dm_addr(dm_addr_b), .dm_rd(dm_rd_b), .dm_byte(dm_byte_b), .dump_valid(dump_valid_b),
        .dump_ready(dump_ready_b), .dump_data(dump_data_b), .dump_idx(dump_idx_b),
        .cycles_run(cycles_run_b), .done(done_b));

    run_dump_ctrl #(.RST_HOLD(1), .RUN_CYCLES(5), .ADDR_W(12), .DATA_W(32),
                    .DUMP_BASE(0), .DUMP_WORDS(0), .CNT_W(32)) u_dut_c (
        .clk(clk), .rst(rst_c), .halt(halt_c), .cpu_rst(cpu_rst_c), .dm_sel(dm_sel_c),
        .dm_addr(dm_addr_c), .dm_rd(dm_rd_c), .dm_byte(dm_byte_c), .dump_valid(dump_valid_c),
        .dump_ready(dump_ready_c), .dump_data(dump_data_c), .dump_idx(dump_idx_c),
        .cycles_run(cycles_run_c), .done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memories: registered read, garbage on the bus when not reading
    always @(posedge clk) begin
        if (dm_rd_a) begin
            dm_byte_a <= mem_a[dm_addr_a];
            addr_log_a.push_back(dm_addr_a);
        end else begin
            dm_byte_a <= 8'($urandom);
        end
        if (dm_rd_b) begin
            dm_byte_b <= mem_b[dm_addr_b];
            rd_cnt_b  <= rd_cnt_b + 1;
        end else begin
            dm_byte_b <= 8'($urandom);
        end
        if (dm_rd_c) rd_cnt_c <= rd_cnt_c + 1;
        if (dump_valid_c) vld_cnt_c <= vld_cnt_c + 1;
        dm_byte_c <= 8'($urandom);
    end

    // Word w of window A: little-endian bytes at (base + 4w + k) mod 16
    function automatic logic [31:0] exp_word_a(input int w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = mem_a[(A_BASE + 4*w + k) % 16];
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_rst_a, dm_sel_a, dm_rd_a, dump_valid_a, done_a} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 10000",
                     {cpu_rst_a, dm_sel_a, dm_rd_a, dump_valid_a, done_a});
        end
        checks++;
        if (dm_addr_a !== 4'd0 || dump_data_a !== 32'd0 || dump_idx_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h idx=%0d expected all zero",
                     dm_addr_a, dump_data_a, dump_idx_a);
        end
        checks++;
        if (cycles_run_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycles: got %0d expected 0", cycles_run_a);
        end
        checks++;
        if (cpu_rst_b !== 1'b1 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: cpu_rst_b=%b done_c=%b expected 1 0", cpu_rst_b, done_c);
        end
    endtask

    task automatic test_run_budget();
        int n;
        int m;
        int k;
        rst_a = 1'b1;
        dump_ready_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        addr_log_a.delete();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_rst_a && n < 50);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL hold_len: cpu_rst high %0d cycles after rst, expected 3", n);
        end
        m = 0;
        while (!cpu_rst_a && m < 50) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (m != 10) begin
            errors++;
            $display("FAIL run_len: cpu_rst low %0d cycles, expected 10", m);
        end
        checks++;
        if (cycles_run_a !== 32'd10 || dm_sel_a !== 1'b1) begin
            errors++;
            $display("FAIL run_freeze: cycles_run=%0d dm_sel=%b expected 10 1", cycles_run_a, dm_sel_a);
        end
        k = 0;
        while (!dump_valid_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k + 1 != 6) begin
            errors++;
            $display("FAIL first_valid_lat_a: %0d cycles after exit, expected 6", k + 1);
        end
    endtask

    task automatic test_wrap_dump();
        int t;
        int stall;
        logic [31:0] held;
        for (int w = 0; w < A_WORDS; w++) begin
            t = 0;
            while (!dump_valid_a && t < 50) begin
                dump_ready_a = 1'($urandom_range(0, 1));
                @(negedge clk);
                t++;
            end
            dump_ready_a = 1'b0;
            checks++;
            if (dump_valid_a !== 1'b1 || dump_data_a !== exp_word_a(w) || dump_idx_a !== 2'(w)) begin
                errors++;
                $display("FAIL word_a%0d: valid=%b data=%h idx=%0d expected 1 %h %0d",
                         w, dump_valid_a, dump_data_a, dump_idx_a, exp_word_a(w), w);
            end
            held  = dump_data_a;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                checks++;
                if (dump_valid_a !== 1'b1 || dump_data_a !== held || dump_idx_a !== 2'(w)) begin
                    errors++;
                    $display("FAIL stall_a%0d: valid=%b data=%h idx=%0d expected 1 %h %0d",
                             w, dump_valid_a, dump_data_a, dump_idx_a, held, w);
                end
            end
            dump_ready_a = 1'b1;
            @(negedge clk);
            dump_ready_a = 1'($urandom_range(0, 1));
            checks++;
            if (dump_valid_a !== 1'b0) begin
                errors++;
                $display("FAIL gap_a%0d: dump_valid=%b after handshake, expected 0", w, dump_valid_a);
            end
        end
        checks++;
        if (done_a !== 1'b1 || dump_idx_a !== 2'd3 || cpu_rst_a !== 1'b1 || cycles_run_a !== 32'd10) begin
            errors++;
            $display("FAIL done_a: done=%b idx=%0d cpu_rst=%b cycles=%0d expected 1 3 1 10",
                     done_a, dump_idx_a, cpu_rst_a, cycles_run_a);
        end
        checks++;
        if (addr_log_a.size() != 4 * A_WORDS) begin
            errors++;
            $display("FAIL rd_count_a: %0d reads, expected %0d", addr_log_a.size(), 4 * A_WORDS);
        end else begin
            for (int i = 0; i < 4 * A_WORDS; i++) begin
                checks++;
                if (addr_log_a[i] !== 4'((A_BASE + i) % 16)) begin
                    errors++;
                    $display("FAIL rd_addr_a%0d: got %h expected %h", i, addr_log_a[i],
                             4'((A_BASE + i) % 16));
                end
            end
        end
    endtask

    task automatic test_abort();
        int  t;
        bit  saw_valid;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        dump_ready_a = 1'b1;
        t = 0;
        while (!(dm_rd_a && dump_idx_a == 2'd1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!(dm_rd_a === 1'b1 && dump_idx_a === 2'd1)) begin
            errors++;
            $display("FAIL abort_reach: dm_rd=%b idx=%0d expected 1 1", dm_rd_a, dump_idx_a);
        end
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_rst_a, dm_sel_a, dm_rd_a, dump_valid_a, done_a} !== 5'b10000 ||
            dm_addr_a !== 4'd0 || dump_data_a !== 32'd0 || dump_idx_a !== 2'd0 ||
            cycles_run_a !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset: flags=%b addr=%h data=%h idx=%0d cycles=%0d expected 10000 0 0 0 0",
                     {cpu_rst_a, dm_sel_a, dm_rd_a, dump_valid_a, done_a},
                     dm_addr_a, dump_data_a, dump_idx_a, cycles_run_a);
        end
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (dump_valid_a) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL abort_valid: dump_valid seen during reset, expected none");
        end
        test_run_budget();
        test_wrap_dump();
    endtask

    task automatic test_halt();
        int n;
        int t;
        int k;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_rst_b && n < 20);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL hold_len_b: cpu_rst high %0d cycles after rst, expected 1", n);
        end
        t = 0;
        while (cycles_run_b !== 32'd4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        halt_b = 1'b1;
        @(negedge clk);
        halt_b = 1'b0;
        checks++;
        if (cpu_rst_b !== 1'b1 || cycles_run_b !== 32'd5 || dm_sel_b !== 1'b1) begin
            errors++;
            $display("FAIL halt_exit: cpu_rst=%b cycles=%0d dm_sel=%b expected 1 5 1",
                     cpu_rst_b, cycles_run_b, dm_sel_b);
        end
        k = 0;
        while (!dump_valid_b && k < 50) begin
            halt_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        halt_b = 1'b0;
        checks++;
        if (k + 1 != 6) begin
            errors++;
            $display("FAIL first_valid_lat_b: %0d cycles after exit, expected 6", k + 1);
        end
    endtask

    task automatic test_stall();
        int rd0;
        int t;
        checks++;
        if (dump_data_b !== 32'h12345678 || dump_idx_b !== 2'd0) begin
            errors++;
            $display("FAIL word_b0: data=%h idx=%0d expected 12345678 0", dump_data_b, dump_idx_b);
        end
        rd0 = rd_cnt_b;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            checks++;
            if (dump_valid_b !== 1'b1 || dump_data_b !== 32'h12345678 || dump_idx_b !== 2'd0 ||
                rd_cnt_b != rd0 || dm_rd_b !== 1'b0) begin
                errors++;
                $display("FAIL stall_b%0d: valid=%b data=%h idx=%0d reads=%0d expected 1 12345678 0 %0d",
                         s, dump_valid_b, dump_data_b, dump_idx_b, rd_cnt_b, rd0);
            end
        end
        dump_ready_b = 1'b1;
        @(negedge clk);
        checks++;
        if (dump_valid_b !== 1'b0 || dump_idx_b !== 2'd1) begin
            errors++;
            $display("FAIL accept_b0: valid=%b idx=%0d expected 0 1", dump_valid_b, dump_idx_b);
        end
        t = 0;
        while (!dump_valid_b && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (dump_valid_b !== 1'b1 || dump_data_b !== 32'hDEADBEEF || dump_idx_b !== 2'd1) begin
            errors++;
            $display("FAIL word_b1: valid=%b data=%h idx=%0d expected 1 deadbeef 1",
                     dump_valid_b, dump_data_b, dump_idx_b);
        end
        @(negedge clk);
        checks++;
        if (done_b !== 1'b1 || dump_valid_b !== 1'b0 || dump_idx_b !== 2'd2) begin
            errors++;
            $display("FAIL done_b: done=%b valid=%b idx=%0d expected 1 0 2", done_b, dump_valid_b, dump_idx_b);
        end
        checks++;
        if (cycles_run_b !== 32'd5 || rd_cnt_b != 8) begin
            errors++;
            $display("FAIL final_b: cycles=%0d reads=%0d expected 5 8", cycles_run_b, rd_cnt_b);
        end
    endtask

    task automatic test_zero_words();
        int t;
        rst_c = 1'b1;
        repeat (2) @(negedge clk);
        rst_c = 1'b0;
        t = 0;
        while (!done_c && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_c !== 1'b1 || cpu_rst_c !== 1'b1 || dm_sel_c !== 1'b1) begin
            errors++;
            $display("FAIL done_c: done=%b cpu_rst=%b dm_sel=%b expected 1 1 1", done_c, cpu_rst_c, dm_sel_c);
        end
        checks++;
        if (rd_cnt_c != 0 || vld_cnt_c != 0 || cycles_run_c !== 32'd5 || dump_idx_c !== 1'b0) begin
            errors++;
            $display("FAIL zero_words: reads=%0d valids=%0d cycles=%0d idx=%0d expected 0 0 5 0",
                     rd_cnt_c, vld_cnt_c, cycles_run_c, dump_idx_c);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rd_cnt_b = 0;
        rd_cnt_c = 0;
        vld_cnt_c = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        halt_a = 1'b0; halt_b = 1'b0; halt_c = 1'b0;
        dump_ready_a = 1'b0; dump_ready_b = 1'b0; dump_ready_c = 1'b1;
        for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);
        mem_b[0] = 8'h78; mem_b[1] = 8'h56; mem_b[2] = 8'h34; mem_b[3] = 8'h12;
        mem_b[4] = 8'hEF; mem_b[5] = 8'hBE; mem_b[6] = 8'hAD; mem_b[7] = 8'hDE;

        test_reset();
        test_run_budget();
        test_wrap_dump();
        test_abort();
        test_halt();
        test_stall();
        test_zero_words();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_dump_ctrl.md
Name: run_dump_ctrl

Overview:
- Synthesizable run/dump sequencer for the pipelined MIPS core.
- Holds the core in reset for a programmable count, lets it run for a cycle budget or until it signals halt, then freezes it.
- After freezing, reads a window of the byte-addressed data memory and streams it out as little-endian words over a valid/ready port.
- Replaces fixed-delay bench timing with deterministic, parametrised, hardware-observable run and dump control.

Parameters:
- RST_HOLD, 1: cycles cpu_rst stays high after rst deasserts (minimum 1).
- RUN_CYCLES, 125: run budget in cycles with cpu_rst low; 0 means unlimited, so only halt ends the run.
- ADDR_W, 12: data-memory byte address width.
- DATA_W, 32: dump word width; must be a multiple of 8. BYTES = DATA_W/8.
- DUMP_BASE, 0: byte address of the first dumped word; must be aligned to BYTES.
- DUMP_WORDS, 32: number of words dumped.
- CNT_W, 32: width of the cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- halt  in  1  core halt indication, sampled only in RUN
- cpu_rst  out  1  reset to the core
- dm_sel  out  1  1 = this block owns the data-memory read port
- dm_addr  out  ADDR_W  byte read address
- dm_rd  out  1  byte read strobe
- dm_byte  in  8  read data, valid exactly 1 cycle after dm_rd
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts the word
- dump_data  out  DATA_W  assembled word; byte at address a+k is placed in bits [8k+7:8k]
- dump_idx  out  clog2(DUMP_WORDS+1)  index of the current word
- cycles_run  out  CNT_W  RUN cycles elapsed; saturates at all-ones
- done  out  1  dump complete

Behaviour:
- Reset: while rst=1, state goes to HOLD and holds there.
  - cpu_rst=1; dm_sel=0; dm_rd=0; dm_addr=0; dump_valid=0; dump_data=0; dump_idx=0; cycles_run=0; done=0.
- HOLD: a hold counter runs from 0. After RST_HOLD cycles with rst=0, go to RUN; cpu_rst falls on entry to RUN.
- RUN:
  - cycles_run increments every cycle.
  - Leave RUN when halt=1, or when (RUN_CYCLES != 0 and cycles_run == RUN_CYCLES-1). Both conditions in the same cycle are treated as a single exit.
  - On exit: cpu_rst=1 and dm_sel=1 from the next cycle; cycles_run freezes.
  - If DUMP_WORDS=0, go straight to DONE. Otherwise go to READ.
- READ (pipelined byte fetch):
  - Issue dm_rd=1 for BYTES consecutive cycles at addresses w_addr+0 .. w_addr+BYTES-1.
  - Capture dm_byte one cycle after each issue into lane k.
  - After the last capture (BYTES+1 cycles after the first issue), go to OUT.
  - dm_rd=0 in every state other than READ.
- OUT:
  - dump_valid=1; dump_data and dump_idx are held stable until dump_valid & dump_ready.
  - On the handshake: dump_idx++ and w_addr += BYTES.
  - If that word was the last (dump_idx == DUMP_WORDS-1), go to DONE. Otherwise go back to READ.
  - dump_valid drops for the cycle after every handshake; there is no back-to-back streaming.
- DONE: done=1, cpu_rst=1, dm_sel=1, dump_valid=0. Stays in DONE until rst.
- Addresses wrap modulo 2^ADDR_W; the window may cross the top of memory.
- dump_ready is ignored outside OUT.
- halt is ignored outside RUN.
- rst asserted in any state, including mid-READ or mid-OUT, aborts immediately: no partial word is emitted and all outputs return to reset values on the next edge.
- Latency from run exit to the first dump_valid: 1 + BYTES + 1 cycles (6 for DATA_W=32).

Decomposition:
- Shared package mips_dbg_pkg holds:
  - state encoding: HOLD, RUN, READ, OUT, DONE;
  - BYTES derivation;
  - helper function clog2.
- One natural sub-module, byte_word_assembler:
  - shift-in lane capture with a 1-cycle-delayed valid;
  - configurable BYTES;
  - raises word_ready after the last lane.

Test Plan:
- RST_HOLD=3, RUN_CYCLES=10, halt=0: rst high 2 cycles, then low. cpu_rst stays high 3 cycles after rst falls, then low exactly 10 cycles. cycles_run=10 when cpu_rst rises again.
- Halt at RUN cycle 4 with RUN_CYCLES=125: cpu_rst rises the next cycle, cycles_run=5. First dump_valid arrives 6 cycles after the exit cycle.
- Memory bytes 0x00..0x03 = 78 56 34 12, bytes 0x04..0x07 = EF BE AD DE, DUMP_WORDS=2, dump_ready=1: outputs 0x12345678 at idx 0, then 0xDEADBEEF at idx 1. done=1 after the second handshake.
- dump_ready held low 20 cycles on word 0: dump_valid, dump_data and dump_idx stay stable; no dm_rd pulses; the word is accepted when ready rises.
- ADDR_W=4, DUMP_BASE=0xC, DUMP_WORDS=2: read addresses C,D,E,F then 0,1,2,3 (wrap).
- rst pulsed during READ of word 1: all outputs reset next cycle, no dump_valid; the full sequence replays from HOLD. DUMP_WORDS=0 goes straight to done with no dm_rd.
